stream_join_seq_ctrl: RTL
=========================

// Module: stream_join_seq_ctrl
// PURPOSE
//  Sequencer in front of a dynamic stream join. Accepts commands {mask, reps} into a small FIFO.
//  Drives the join's select mask from the head command for reps+1 output handshakes, then retires it.
//  Sits between N_INP producer streams and one consumer. The data channel flows outside this block.
//  Only the valid/ready handshakes are joined here.
// PARAMETERS
//  N_INP      2  number of input streams (>=1)
//  DEPTH      4  command FIFO entries (>=1, any value; pointers wrap at DEPTH-1)
//  CNT_WIDTH  8  width of the reps field; one command covers 1..2**CNT_WIDTH joins
// PORTS
//  clk_i        in   1          clock
//  rst_i        in   1          asynchronous reset, active-high
//  cmd_valid_i  in   1          command valid
//  cmd_ready_o  out  1          command ready (= FIFO not full)
//  cmd_mask_i   in   N_INP      streams to join for this command
//  cmd_reps_i   in   CNT_WIDTH  number of joins minus one
//  inp_valid_i  in   N_INP      input stream valids
//  inp_ready_o  out  N_INP      input stream readies
//  oup_valid_o  out  1          joined output valid
//  oup_ready_i  in   1          joined output ready
//  busy_o       out  1          FIFO non-empty
//  done_o       out  1          1-cycle pulse when a command retires
//  stall_cnt_o  out  32         stall counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset, async assert: FIFO flushed, rep_q=0, state=IDLE. Also applies mid-command: the pending command is lost.
//  Outputs in reset: cmd_ready_o=1, oup_valid_o=0, inp_ready_o=0, busy_o=0, done_o=0, stall_cnt_o=0.
//  FSM (state enum from package):
//    IDLE: FIFO empty. Join select forced to 0, so oup_valid_o=0 and inp_ready_o=0.
//    RUN:  FIFO non-empty. Select = head.mask.
//    IDLE->RUN on push. RUN->IDLE on retire when no other entry remains.
//  Push: cmd_valid_i & cmd_ready_o. Entry written at the tail.
//    A pushed command is never active in the same cycle; earliest effect is the next cycle (latency 1).
//  Join, combinational in RUN:
//    oup_valid_o = &(inp_valid_i | ~mask) & |mask.
//    inp_ready_o[i] = oup_valid_o & oup_ready_i for all i.
//    Unselected streams also see ready. The consumer is responsible for ignoring them.
//  On output handshake (oup_valid_o & oup_ready_i):
//    rep_q != head.reps: rep_q++.
//    Otherwise: retire, meaning pop the head, rep_q<=0, done_o=1 next... no: done_o is registered and pulses the cycle after retire.
//  Zero-mask command: retires in its first RUN cycle with no handshake. done_o still pulses; reps is ignored.
//  Full FIFO: cmd_ready_o=0 even if a pop happens the same cycle (no full pass-through).
//    Push and pop in the same cycle while not full: both take effect, count is unchanged.
//  Arithmetic: rep_q is CNT_WIDTH bits and compared for equality with reps; it never overflows.
//    The FIFO count uses $clog2(DEPTH+1) bits.
//  Sel and control never depend combinationally on cmd_*; only FIFO contents are used.
//  Assertions (translate_off): N_INP>=1, DEPTH>=1, CNT_WIDTH>=1, no push when !cmd_ready_o.
// CONFIGURATION
//  Macro COMMON_CELLS_JOIN_SEQ_STALL_CNT_EN.
//  Defined: stall_cnt_o counts cycles with state==RUN & |mask & !oup_valid_o.
//    It saturates at 2**32-1 and clears only on reset.
//  Undefined: no counter register; stall_cnt_o tied to 0.
// STRUCTURE
//  Package stream_join_seq_pkg:
//    seq_state_e {IDLE, RUN}.
//    Default constants DefaultDepth=4 and DefaultCntWidth=8.
//    Stall counter width constant StallCntWidth=32.
//  Sub-module: stream_join_dynamic (N_INP), fed sel = (state==RUN) ? head.mask : '0.
//  FIFO storage and pointers are local to this module; no second sub-module.
// TESTING
//  1 Reset, then idle with inp_valid_i=2'b11 -> oup_valid_o=0, inp_ready_o=0, cmd_ready_o=1, busy_o=0.
//  2 Push {mask=2'b11, reps=2}, both valid, oup_ready_i=1 -> exactly 3 handshakes;
//    done_o pulses once; busy_o drops afterwards.
//  3 Push {mask=2'b01, reps=0}, inp_valid_i=2'b01 -> 1 handshake even though stream 1 is not valid;
//    inp_ready_o=2'b11 during that handshake.
//  4 Fill DEPTH=4 commands while oup_ready_i=0 -> cmd_ready_o=0.
//    Fifth push is held until a retire frees an entry; commands retire in FIFO order.
//  5 Push {mask=0, reps=5} then {mask=2'b10, reps=0} -> first retires in 1 cycle with no handshake;
//    second completes on inp_valid_i[1]; done_o pulses twice.
//  6 Assert rst_i mid-command (rep_q=1 of reps=3) -> FIFO empty, oup_valid_o=0 immediately.
//    With the macro enabled, stall_cnt_o=0; stall cycles with mask=2'b11 and inp_valid_i=2'b01
//    increment it by 1 per cycle.

Source files
------------

// File: rtl/stream_join_seq_pkg.sv
// Shared types and constants for the stream join sequencer.
package stream_join_seq_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } seq_state_e;

   localparam int unsigned DefaultDepth    = 4;
   localparam int unsigned DefaultCntWidth = 8;
   localparam int unsigned StallCntWidth   = 32;

endpackage

// File: rtl/stream_join_dynamic.sv
// Dynamic valid/ready join: only the streams selected in sel take part in the join.
// An all-zero select never produces an output valid.
module stream_join_dynamic
   import stream_join_seq_pkg::*;
#(
   parameter int unsigned N_INP = 2
) (
   input  logic [N_INP-1:0] sel,
   input  logic [N_INP-1:0] inp_valid,
   output logic [N_INP-1:0] inp_ready,
   output logic             oup_valid,
   input  logic             oup_ready
);

   // Output is valid once every selected stream is valid; all inputs see the same ready.
   always_comb begin
      oup_valid = (&(inp_valid | ~sel)) & (|sel);
      inp_ready = {N_INP{oup_valid & oup_ready}};
   end

endmodule

// File: rtl/stream_join_seq_ctrl.sv
// Command sequencer for a dynamic stream join. Commands {mask, reps} queue in a small
// FIFO; the head command selects the joined streams for reps+1 output handshakes.
// Optional stall counter enabled by defining COMMON_CELLS_JOIN_SEQ_STALL_CNT_EN.
module stream_join_seq_ctrl
   import stream_join_seq_pkg::*;
#(
   parameter int unsigned N_INP     = 2,
   parameter int unsigned DEPTH     = DefaultDepth,
   parameter int unsigned CNT_WIDTH = DefaultCntWidth
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     cmd_valid_i,
   output logic                     cmd_ready_o,
   input  logic [N_INP-1:0]         cmd_mask_i,
   input  logic [CNT_WIDTH-1:0]     cmd_reps_i,
   input  logic [N_INP-1:0]         inp_valid_i,
   output logic [N_INP-1:0]         inp_ready_o,
   output logic                     oup_valid_o,
   input  logic                     oup_ready_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [StallCntWidth-1:0] stall_cnt_o
);

   localparam int unsigned PtrWidth   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CountWidth = $clog2(DEPTH + 1);

   logic [N_INP-1:0]     mask_mem_q [DEPTH];
   logic [CNT_WIDTH-1:0] reps_mem_q [DEPTH];
   logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CountWidth-1:0] count_q;
   logic [CNT_WIDTH-1:0] rep_q, rep_d;
   seq_state_e           state_q, state_d;
   logic                 done_q;
   logic                 push, retire, handshake;
   logic [N_INP-1:0]     head_mask, sel;
   logic [CNT_WIDTH-1:0] head_reps;

   // Full blocks new commands even when the head retires this cycle.
   assign cmd_ready_o = (count_q != CountWidth'(DEPTH));
   assign push        = cmd_valid_i & cmd_ready_o;
   assign head_mask   = mask_mem_q[rd_ptr_q];
   assign head_reps   = reps_mem_q[rd_ptr_q];
   assign sel         = (state_q == RUN) ? head_mask : '0;
   assign handshake   = oup_valid_o & oup_ready_i;
   assign busy_o      = (count_q != '0);
   assign done_o      = done_q;

   stream_join_dynamic #(
      .N_INP (N_INP)
   ) i_join (
      .sel       (sel),
      .inp_valid (inp_valid_i),
      .inp_ready (inp_ready_o),
      .oup_valid (oup_valid_o),
      .oup_ready (oup_ready_i)
   );

   // Command storage: written at the tail, no reset needed since pointers define validity.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mask_mem_q[wr_ptr_q] <= cmd_mask_i;
         reps_mem_q[wr_ptr_q] <= cmd_reps_i;
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= (wr_ptr_q == PtrWidth'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
         end
         if (retire) begin
            rd_ptr_q <= (rd_ptr_q == PtrWidth'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
         end
         if (push && !retire) begin
            count_q <= count_q + 1'b1;
         end else if (!push && retire) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   // State, repetition counter and registered done pulse.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         rep_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rep_q   <= rep_d;
         done_q  <= retire;
      end
   end

   // Next state: count handshakes on the head command and retire it after reps+1 joins.
   always_comb begin
      state_d = state_q;
      rep_d   = rep_q;
      retire  = 1'b0;
      case (state_q)
         IDLE: begin
            if (push) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (head_mask == '0) begin
               retire = 1'b1;
            end else if (handshake) begin
               if (rep_q == head_reps) begin
                  retire = 1'b1;
               end else begin
                  rep_d = rep_q + 1'b1;
               end
            end
            if (retire) begin
               rep_d = '0;
               if ((count_q == CountWidth'(1)) && !push) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef COMMON_CELLS_JOIN_SEQ_STALL_CNT_EN
   logic [StallCntWidth-1:0] stall_q;

   // Saturating count of cycles where an active join waits on its inputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_q <= '0;
      end else if ((state_q == RUN) && (|head_mask) && !oup_valid_o && !(&stall_q)) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   assign stall_cnt_o = stall_q;
`else
   assign stall_cnt_o = '0;
`endif

`ifndef SYNTHESIS
   a_n_inp:     assert property (@(posedge clk_i) N_INP >= 1);
   a_depth:     assert property (@(posedge clk_i) DEPTH >= 1);
   a_cnt_width: assert property (@(posedge clk_i) CNT_WIDTH >= 1);
   a_no_ovf:    assert property (@(posedge clk_i) disable iff (rst_i)
                                 push |-> (count_q < CountWidth'(DEPTH)));
`endif

endmodule
